// File: rtl/sram_acc_pkg.sv
// Shared types and constants for the accumulating partial-sum SRAM.
//   psum_t   : one lane at the default lane width
//   state_e  : clear-sweep / run controller states
//   sat_max / sat_min : two's-complement clamp bounds for a given lane width
package sram_acc_pkg;

    localparam int unsigned PSUM_BW_DEF = 16;

    typedef logic signed [PSUM_BW_DEF-1:0] psum_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Largest representable value of a bw-bit signed lane.
    function automatic int sat_max(input int unsigned bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    // Smallest representable value of a bw-bit signed lane.
    function automatic int sat_min(input int unsigned bw);
        return -(1 << (bw - 1));
    endfunction

endpackage

// File: rtl/sram_acc_lane_add.sv
// One psum lane: signed add with optional saturation.
//   a, b   : lane operands (two's complement)
//   sum_c  : clamped (SAT!=0) or truncated sum, combinational
//   ovf_c  : high when the true sum does not fit in PSUM_BW bits
module sram_acc_lane_add
    import sram_acc_pkg::*;
#(
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned SAT     = 1
) (
    input  logic signed [PSUM_BW-1:0] a,
    input  logic signed [PSUM_BW-1:0] b,
    output logic signed [PSUM_BW-1:0] sum_c,
    output logic                      ovf_c
);

    localparam logic signed [PSUM_BW-1:0] MAX_V = PSUM_BW'(sat_max(PSUM_BW));
    localparam logic signed [PSUM_BW-1:0] MIN_V = PSUM_BW'(sat_min(PSUM_BW));

    logic [PSUM_BW:0] full_c;

    // Extended sum; overflow when the two top bits disagree.
    always_comb begin
        full_c = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        ovf_c  = full_c[PSUM_BW] ^ full_c[PSUM_BW-1];
        sum_c  = full_c[PSUM_BW-1:0];
        if ((SAT != 0) && ovf_c) begin
            sum_c = full_c[PSUM_BW] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/sram_acc.sv
// Dual-port partial-sum SRAM with in-place lane-wise accumulate.
//   CLK, RSTN        : clock, asynchronous active-low reset
//   CEN, REN, WEN    : active-low chip / read / write enables
//   ACC              : with a write, add D to the stored word instead of overwriting
//   CLR              : pulse in RUN to start a zeroing sweep
//   A_rd, A_wr, D    : read address, write address, write data (LANES lanes)
//   Q                : registered read data (read-first, forwards committing write)
//   BUSY             : high while the clear sweep runs; requests ignored
//   OVF              : sticky lane overflow flag, cleared by CLR
module sram_acc
    import sram_acc_pkg::*;
#(
    parameter int unsigned NUM     = 2048,
    parameter int unsigned LANES   = 8,
    parameter int unsigned PSUM_BW = 16,
    parameter int unsigned SAT     = 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       CEN,
    input  logic                       REN,
    input  logic                       WEN,
    input  logic                       ACC,
    input  logic                       CLR,
    input  logic [$clog2(NUM)-1:0]     A_rd,
    input  logic [$clog2(NUM)-1:0]     A_wr,
    input  logic [LANES*PSUM_BW-1:0]   D,
    output logic [LANES*PSUM_BW-1:0]   Q,
    output logic                       BUSY,
    output logic                       OVF
);

    localparam int unsigned AW = $clog2(NUM);
    localparam int unsigned W  = LANES * PSUM_BW;

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   q_q, q_d;

    // Write pipeline stage: captured on acceptance, committed one edge later.
    logic           s_vld_q, s_vld_d;
    logic           s_acc_q, s_acc_d;
    logic [AW-1:0]  s_addr_q, s_addr_d;
    logic [W-1:0]   s_data_q, s_data_d;
    logic [W-1:0]   s_old_q, s_old_d;

    logic [W-1:0]     sum_word_c;
    logic [W-1:0]     new_word_c;
    logic [LANES-1:0] lane_ovf_c;
    logic             run_c, wr_acc_c, rd_acc_c, sweep_c;

    logic [W-1:0]   mem_q [NUM];

    // Per-lane adders on the committing stage.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sram_acc_lane_add #(
            .PSUM_BW (PSUM_BW),
            .SAT     (SAT)
        ) u_add (
            .a     (s_old_q[i*PSUM_BW +: PSUM_BW]),
            .b     (s_data_q[i*PSUM_BW +: PSUM_BW]),
            .sum_c (sum_word_c[i*PSUM_BW +: PSUM_BW]),
            .ovf_c (lane_ovf_c[i])
        );
    end

    assign new_word_c = s_acc_q ? sum_word_c : s_data_q;

    // Controller, request acceptance and forwarding.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        q_d      = q_q;
        s_vld_d  = 1'b0;
        s_acc_d  = s_acc_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_old_d  = s_old_q;
        sweep_c  = 1'b0;

        run_c    = (state_q == RUN);
        wr_acc_c = run_c && !CEN && !WEN;
        rd_acc_c = run_c && !CEN && !REN;

        if (s_vld_q && s_acc_q && (|lane_ovf_c)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            CLEAR: begin
                sweep_c = 1'b1;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == AW'(NUM - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Clearing wins over an overflow committing on the same edge.
                if (CLR) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = CLEAR;
        endcase

        if (wr_acc_c) begin
            s_vld_d  = 1'b1;
            s_acc_d  = ACC;
            s_addr_d = A_wr;
            s_data_d = D;
            s_old_d  = (s_vld_q && (s_addr_q == A_wr)) ? new_word_c : mem_q[A_wr];
        end

        if (rd_acc_c) begin
            q_d = (s_vld_q && (s_addr_q == A_rd)) ? new_word_c : mem_q[A_rd];
        end

        busy_d = (state_d == CLEAR);
    end

    // Control and pipeline registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            ovf_q    <= 1'b0;
            q_q      <= '0;
            s_vld_q  <= 1'b0;
            s_acc_q  <= 1'b0;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_old_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            q_q      <= q_d;
            s_vld_q  <= s_vld_d;
            s_acc_q  <= s_acc_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_old_q  <= s_old_d;
        end
    end

    // Array: pending commit first, so a sweep write to the same word wins.
    always_ff @(posedge CLK) begin
        if (s_vld_q) begin
            mem_q[s_addr_q] <= new_word_c;
        end
        if (sweep_c) begin
            mem_q[cnt_q] <= '0;
        end
    end

    assign Q    = q_q;
    assign BUSY = busy_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_sram_acc.sv
module tb_sram_acc;

    localparam int unsigned NUM   = 2048;
    localparam int unsigned LANES = 8;
    localparam int unsigned BW    = 16;
    localparam int unsigned AW    = 11;
    localparam int unsigned W     = LANES * BW;

    logic          CLK, RSTN, CEN, REN, WEN, ACC, CLR;
    logic [AW-1:0] A_rd, A_wr;
    logic [W-1:0]  D;
    logic [W-1:0]  q_s, q_w;
    logic          busy_s, busy_w, ovf_s, ovf_w;

    int checks = 0;
    int errors = 0;

    // Reference: index 0 = saturating instance, 1 = wrapping instance.
    int mdl   [2][NUM][LANES];
    int exp_q [2][LANES];
    bit mdl_ovf [2];
    int busy_left;

    sram_acc #(.NUM(NUM), .LANES(LANES), .PSUM_BW(BW), .SAT(1)) dut_s (
        .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .REN(REN), .WEN(WEN), .ACC(ACC), .CLR(CLR),
        .A_rd(A_rd), .A_wr(A_wr), .D(D), .Q(q_s), .BUSY(busy_s), .OVF(ovf_s)
    );

    sram_acc #(.NUM(NUM), .LANES(LANES), .PSUM_BW(BW), .SAT(0)) dut_w (
        .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .REN(REN), .WEN(WEN), .ACC(ACC), .CLR(CLR),
        .A_rd(A_rd), .A_wr(A_wr), .D(D), .Q(q_w), .BUSY(busy_w), .OVF(ovf_w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int lane_of(input logic [W-1:0] w, input int i);
        logic signed [BW-1:0] v;
        v = w[i*BW +: BW];
        return int'(v);
    endfunction

    function automatic logic [W-1:0] splat(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word(input int lo, input int hi);
        logic [W-1:0] r;
        int v;
        for (int i = 0; i < LANES; i++) begin
            v = lo + int'($urandom % 32'(hi - lo + 1));
            r[i*BW +: BW] = BW'(v);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_vec(input int s);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*BW +: BW] = BW'(exp_q[s][i]);
        return r;
    endfunction

    // True-sum arithmetic, then clamp or wrap into 16-bit range.
    function automatic int ref_add(input bit sat, input int a, input int b, output bit o);
        int s;
        s = a + b;
        o = (s > 32767) || (s < -32768);
        if (!o) return s;
        if (sat) return (s > 32767) ? 32767 : -32768;
        return (s > 32767) ? s - 65536 : s + 65536;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < NUM; a++)
                for (int i = 0; i < LANES; i++) mdl[s][a][i] = 0;
    endtask

    // One clock: drive inputs, apply the transaction to the model, sample at negedge.
    task automatic step(input bit cen, input bit ren, input bit wen, input bit acc,
                        input bit clr, input logic [AW-1:0] ard,
                        input logic [AW-1:0] awr, input logic [W-1:0] d);
        bit o;
        CEN = cen; REN = ren; WEN = wen; ACC = acc; CLR = clr;
        A_rd = ard; A_wr = awr; D = d;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (!cen && !ren)
                for (int s = 0; s < 2; s++)
                    for (int i = 0; i < LANES; i++) exp_q[s][i] = mdl[s][ard][i];
            if (!cen && !wen)
                for (int s = 0; s < 2; s++)
                    for (int i = 0; i < LANES; i++) begin
                        if (acc) begin
                            mdl[s][awr][i] = ref_add(s == 0, mdl[s][awr][i], lane_of(d, i), o);
                            if (o) mdl_ovf[s] = 1'b1;
                        end else begin
                            mdl[s][awr][i] = lane_of(d, i);
                        end
                    end
            if (clr) begin
                busy_left  = NUM;
                mdl_ovf[0] = 1'b0;
                mdl_ovf[1] = 1'b0;
                model_clear();
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input bit acc);
        step(1'b0, 1'b1, 1'b0, acc, 1'b0, '0, a, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, '0, '0);
    endtask

    // Count BUSY-high cycles per instance; optionally inject requests and a CLR meanwhile.
    task automatic measure_busy(input int inject, output int ns, output int nw);
        ns = 0;
        nw = 0;
        for (int k = 0; k < 3 * NUM; k++) begin
            if (!busy_s && !busy_w) break;
            if (busy_s) ns++;
            if (busy_w) nw++;
            if (k < inject)
                step(1'b0, 1'b0, 1'b0, 1'b1, (k == inject / 2), AW'(9), AW'(9),
                     rand_word(-100, 100));
            else
                idle();
        end
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        for (int s = 0; s < 2; s++) begin
            mdl_ovf[s] = 1'b0;
            for (int i = 0; i < LANES; i++) exp_q[s][i] = 0;
        end
        model_clear();
        repeat (2) @(negedge CLK);
        busy_left = NUM;
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        int ns, nw;
        RSTN = 1'b0;
        CEN = $urandom; REN = $urandom; WEN = $urandom; ACC = $urandom; CLR = $urandom;
        A_rd = AW'($urandom); A_wr = AW'($urandom); D = rand_word(-32768, 32767);
        repeat (3) @(negedge CLK);
        checks++;
        if (q_s !== '0 || q_w !== '0) begin
            errors++;
            $display("FAIL reset_q: got %h / %h expected 0", q_s, q_w);
        end
        checks++;
        if (busy_s !== 1'b1 || busy_w !== 1'b1 || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy %b%b ovf %b%b expected busy 11 ovf 00",
                     busy_s, busy_w, ovf_s, ovf_w);
        end
        CEN = 1'b1; REN = 1'b1; WEN = 1'b1; ACC = 1'b0; CLR = 1'b0;
        do_reset();
        measure_busy(0, ns, nw);
        checks++;
        if (ns != NUM || nw != NUM) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d / %0d expected %0d", ns, nw, NUM);
        end
        rd(AW'(0));
        rd(AW'(22));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL reset_read22: got %h / %h expected %h", q_s, q_w, exp_vec(0));
        end
        wr(AW'(NUM - 1), splat(77), 1'b0);
        rd(AW'(22));
        rd(AW'(NUM - 1));
        rd(AW'(0));
        checks++;
        if (q_s !== '0 || q_w !== '0) begin
            errors++;
            $display("FAIL reset_read0: got %h / %h expected 0", q_s, q_w);
        end
        do_reset();
        measure_busy(0, ns, nw);
        rd(AW'(NUM - 1));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL reset_read_last: got %h / %h expected %h", q_s, q_w, exp_vec(0));
        end
    endtask

    task automatic test_fwd_chain();
        logic [AW-1:0] a;
        wr(AW'(7), splat(5), 1'b0);
        wr(AW'(7), splat(3), 1'b1);
        rd(AW'(7));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL fwd_chain: got %h / %h expected %h", q_s, q_w, exp_vec(0));
        end
        for (int n = 0; n < 4; n++) begin
            a = AW'($urandom_range(NUM - 1, 0));
            wr(a, rand_word(-1000, 1000), 1'b0);
            wr(a, rand_word(-1000, 1000), 1'b1);
            wr(a, rand_word(-1000, 1000), 1'b1);
            rd(a);
            checks++;
            if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
                errors++;
                $display("FAIL fwd_chain_rand: addr %0d got %h expected %h", a, q_s, exp_vec(0));
            end
        end
        idle();
        checks++;
        if (ovf_s !== mdl_ovf[0] || ovf_w !== mdl_ovf[1]) begin
            errors++;
            $display("FAIL fwd_chain_ovf: got %b%b expected %b%b", ovf_s, ovf_w,
                     mdl_ovf[0], mdl_ovf[1]);
        end
    endtask

    task automatic test_acc4();
        repeat (4) wr(AW'(100), splat(-2), 1'b1);
        rd(AW'(100));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL acc4: got %h / %h expected %h", q_s, q_w, exp_vec(0));
        end
    endtask

    task automatic test_sat();
        int ns, nw;
        wr(AW'(50), splat(32767), 1'b0);
        wr(AW'(50), splat(1), 1'b1);
        idle();
        rd(AW'(50));
        checks++;
        if (q_s !== exp_vec(0)) begin
            errors++;
            $display("FAIL sat_pos: got %h expected %h", q_s, exp_vec(0));
        end
        checks++;
        if (q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL wrap_pos: got %h expected %h", q_w, exp_vec(1));
        end
        checks++;
        if (ovf_s !== mdl_ovf[0] || ovf_w !== mdl_ovf[1]) begin
            errors++;
            $display("FAIL ovf_set: got %b%b expected %b%b", ovf_s, ovf_w,
                     mdl_ovf[0], mdl_ovf[1]);
        end
        wr(AW'(51), splat(-32768), 1'b0);
        wr(AW'(51), splat(-1), 1'b1);
        rd(AW'(51));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL sat_neg: got %h / %h expected %h / %h", q_s, q_w,
                     exp_vec(0), exp_vec(1));
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, '0);
        checks++;
        if (ovf_s !== 1'b0 || ovf_w !== 1'b0 || busy_s !== 1'b1) begin
            errors++;
            $display("FAIL clr_flags: ovf %b%b busy %b expected ovf 00 busy 1",
                     ovf_s, ovf_w, busy_s);
        end
        measure_busy(0, ns, nw);
        checks++;
        if (ns != NUM || nw != NUM) begin
            errors++;
            $display("FAIL clr_busy_len: got %0d / %0d expected %0d", ns, nw, NUM);
        end
        rd(AW'(50));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL clr_zeroed: got %h / %h expected %h", q_s, q_w, exp_vec(0));
        end
    endtask

    task automatic test_same_cycle();
        wr(AW'(3), splat(10), 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(3), AW'(3), splat(20));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL same_cycle_old: got %h expected %h", q_s, exp_vec(0));
        end
        rd(AW'(3));
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
            errors++;
            $display("FAIL same_cycle_new: got %h expected %h", q_s, exp_vec(0));
        end
    endtask

    task automatic test_random();
        bit cen, ren, wen, acc;
        logic [W-1:0] d;
        for (int n = 0; n < 400; n++) begin
            cen = ($urandom_range(9, 0) == 0);
            ren = $urandom;
            wen = $urandom;
            acc = ($urandom_range(3, 0) != 0);
            d   = ($urandom_range(1, 0) == 0) ? rand_word(-32768, 32767) : rand_word(-50, 50);
            step(cen, ren, wen, acc, 1'b0, AW'($urandom_range(3, 0)),
                 AW'($urandom_range(3, 0)), d);
            checks++;
            if (q_s !== exp_vec(0) || q_w !== exp_vec(1)) begin
                errors++;
                $display("FAIL random_q: iter %0d got %h / %h expected %h / %h", n,
                         q_s, q_w, exp_vec(0), exp_vec(1));
            end
        end
        idle();
        checks++;
        if (ovf_s !== mdl_ovf[0] || ovf_w !== mdl_ovf[1]) begin
            errors++;
            $display("FAIL random_ovf: got %b%b expected %b%b", ovf_s, ovf_w,
                     mdl_ovf[0], mdl_ovf[1]);
        end
    endtask

    task automatic test_busy_ignore();
        int ns, nw;
        wr(AW'(9), splat(1234), 1'b0);
        do_reset();
        measure_busy(6, ns, nw);
        checks++;
        if (ns != NUM || nw != NUM) begin
            errors++;
            $display("FAIL busy_ignore_len: got %0d / %0d expected %0d", ns, nw, NUM);
        end
        rd(AW'(9));
        idle();
        checks++;
        if (q_s !== exp_vec(0) || q_w !== exp_vec(1) || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_mem: got %h ovf %b%b expected %h ovf 00",
                     q_s, ovf_s, ovf_w, exp_vec(0));
        end
    endtask

    initial begin
        RSTN = 1'b1;
        CEN = 1'b1; REN = 1'b1; WEN = 1'b1; ACC = 1'b0; CLR = 1'b0;
        A_rd = '0; A_wr = '0; D = '0;
        busy_left = NUM;
        #2;
        test_reset();
        test_fwd_chain();
        test_acc4();
        test_same_cycle();
        test_sat();
        test_random();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
